// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the receiver and transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int MID_SAMPLE         = OVERSAMPLE_DEFAULT / 2 - 1;
  localparam int DATA_BITS_DEFAULT  = 8;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic D,
  output logic Q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta <= RESET_VAL;
      Q    <= RESET_VAL;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled bit recovery and a valid/ack holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Tick,
  input  logic                 RxD,
  input  logic                 RxAck,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 RxFrameErr,
  output logic                 RxOverrun,
  output logic                 RxBusy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  =
    TW'((OVERSAMPLE == OVERSAMPLE_DEFAULT) ? MID_SAMPLE : OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rxd_s;
  uart_state_t          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample_stop;
  logic                 deliver;
  logic                 stop_bad;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .Clk (Clk),
    .Rst (Rst),
    .D   (RxD),
    .Q   (rxd_s)
  );

  // The stop-bit sample decides between handing a byte over and flagging a framing error.
  assign sample_stop = Tick && (state == STOP) && (tick_cnt == TICK_LAST);
  assign deliver     = sample_stop && rxd_s;
  assign stop_bad    = sample_stop && !rxd_s;

  // Frame FSM: advances only on Tick, counts oversample ticks and shifts data bits in LSB first.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      RxBusy     <= 1'b0;
      RxFrameErr <= 1'b0;
    end else begin
      RxFrameErr <= stop_bad;
      if (Tick) begin
        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state    <= START;
              tick_cnt <= '0;
              RxBusy   <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (rxd_s) begin
                state  <= IDLE;
                RxBusy <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rxd_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (rxd_s) begin
                state  <= IDLE;
                RxBusy <= 1'b0;
              end else begin
                // A low stop bit usually means a break; wait for the line to recover.
                state <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          BREAK: begin
            if (rxd_s) begin
              state  <= IDLE;
              RxBusy <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            RxBusy   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Holding register: a new byte replaces the old one only if it was consumed, else it is dropped.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      RxData    <= '0;
      RxValid   <= 1'b0;
      RxOverrun <= 1'b0;
    end else begin
      RxOverrun <= 1'b0;
      if (deliver) begin
        if (!RxValid || RxAck) begin
          RxData  <= shreg;
          RxValid <= 1'b1;
        end else begin
          RxOverrun <= 1'b1;
        end
      end else if (RxAck) begin
        RxValid <= 1'b0;
      end
    end
  end

endmodule
